enigma_step_ctrl: RTL and testbench

Keystroke sequencer and rotor-stepping controller for the Enigma datapath. It accepts one decoded one-hot keystroke at a time from the keyboard decoder and advances the three rotor positions with Enigma stepping rules, including the middle-rotor double step. It then holds the combinational plugboard/rotor/reflector path stable for a settle window, captures the enciphered letter and presents it to the GUI. It replaces the free-running KEY[1..3] rotor buttons as the single owner of `state1`..`state3`, and also services position loads and manual single-rotor advances.

---
 rtl/enigma_step_ctrl.sv | 107 ++++++++++
 tb/tb_enigma_step_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/enigma_step_ctrl.sv
// enigma_step_ctrl: keystroke sequencer and Enigma rotor-stepping controller with settle/capture.
module enigma_step_ctrl #(
    parameter int NOTCH1 = 16,
    parameter int NOTCH2 = 4,
    parameter int SETTLE = 4
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [25:0] key_onehot,
    input  logic        load,
    input  logic [4:0]  load_pos1,
    input  logic [4:0]  load_pos2,
    input  logic [4:0]  load_pos3,
    input  logic [2:0]  rot_btn,
    input  logic [25:0] enc_in,
    output logic [4:0]  state1,
    output logic [4:0]  state2,
    output logic [4:0]  state3,
    output logic        busy,
    output logic        out_valid,
    output logic [25:0] out_letter,
    output logic        err
);
    typedef enum logic {IDLE, SETTLE_ST} fsm_t;

    fsm_t        st, st_n;
    logic [3:0]  cnt, cnt_n;
    logic [4:0]  s1_n, s2_n, s3_n;
    logic        busy_n, ov_n, err_n;
    logic [25:0] ol_n;
    logic        one_hot, key_ok;

    function automatic logic [4:0] inc(input logic [4:0] x);
        return x == 5'd25 ? 5'd0 : x + 5'd1;
    endfunction

    assign one_hot = (key_onehot != '0) && ((key_onehot & (key_onehot - 26'd1)) == '0);
    assign key_ok  = key_valid && one_hot;

    always_comb begin
        st_n   = st;
        cnt_n  = cnt;
        s1_n   = state1;
        s2_n   = state2;
        s3_n   = state3;
        busy_n = busy;
        ov_n   = 1'b0;
        ol_n   = out_letter;
        err_n  = 1'b0;
        if (st == IDLE) begin
            err_n = key_valid && !one_hot;
            if (key_ok) begin
                // notch tests use the positions before this keystroke steps them
                s1_n   = inc(state1);
                s2_n   = (state1 == 5'(NOTCH1) || state2 == 5'(NOTCH2)) ? inc(state2) : state2;
                s3_n   = (state2 == 5'(NOTCH2)) ? inc(state3) : state3;
                st_n   = SETTLE_ST;
                cnt_n  = 4'(SETTLE - 1);
                busy_n = 1'b1;
            end else if (load) begin
                s1_n  = load_pos1 > 5'd25 ? 5'd0 : load_pos1;
                s2_n  = load_pos2 > 5'd25 ? 5'd0 : load_pos2;
                s3_n  = load_pos3 > 5'd25 ? 5'd0 : load_pos3;
                err_n = err_n || load_pos1 > 5'd25 || load_pos2 > 5'd25 || load_pos3 > 5'd25;
            end else begin
                s1_n = rot_btn[0] ? inc(state1) : state1;
                s2_n = rot_btn[1] ? inc(state2) : state2;
                s3_n = rot_btn[2] ? inc(state3) : state3;
            end
        end else begin
            err_n = key_valid || load || (rot_btn != 3'b000);
            if (cnt == 4'd0) begin
                ol_n   = enc_in;
                ov_n   = 1'b1;
                busy_n = 1'b0;
                st_n   = IDLE;
            end else begin
                cnt_n = cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            st         <= IDLE;
            cnt        <= '0;
            state1     <= '0;
            state2     <= '0;
            state3     <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_letter <= '0;
            err        <= 1'b0;
        end else begin
            st         <= st_n;
            cnt        <= cnt_n;
            state1     <= s1_n;
            state2     <= s2_n;
            state3     <= s3_n;
            busy       <= busy_n;
            out_valid  <= ov_n;
            out_letter <= ol_n;
            err        <= err_n;
        end
    end
endmodule

// File: tb/tb_enigma_step_ctrl.sv
// tb_enigma_step_ctrl: directed self-checking bench for enigma_step_ctrl.
module tb_enigma_step_ctrl;
    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b0;
    logic        key_valid = 1'b0;
    logic [25:0] key_onehot = '0;
    logic        load = 1'b0;
    logic [4:0]  load_pos1 = '0, load_pos2 = '0, load_pos3 = '0;
    logic [2:0]  rot_btn = '0;
    logic [25:0] enc_in = '0;
    logic [4:0]  state1, state2, state3;
    logic        busy, out_valid, err;
    logic [25:0] out_letter;
    int          tests = 0, fails = 0;

    enigma_step_ctrl dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .key_valid(key_valid), .key_onehot(key_onehot),
        .load(load), .load_pos1(load_pos1), .load_pos2(load_pos2), .load_pos3(load_pos3),
        .rot_btn(rot_btn), .enc_in(enc_in), .state1(state1), .state2(state2), .state3(state3),
        .busy(busy), .out_valid(out_valid), .out_letter(out_letter), .err(err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
        chk({tag, "_L"}, {27'd0, state3}, {27'd0, l});
        chk({tag, "_M"}, {27'd0, state2}, {27'd0, m});
        chk({tag, "_R"}, {27'd0, state1}, {27'd0, r});
    endtask

    task automatic do_load(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
        load = 1'b1; load_pos3 = l; load_pos2 = m; load_pos1 = r;
        tick();
        load = 1'b0;
    endtask

    task automatic key(input logic [25:0] k);
        key_valid = 1'b1; key_onehot = k;
        tick();
        key_valid = 1'b0; key_onehot = '0;
    endtask

    task automatic finish_settle(input logic [25:0] exp_letter);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("settle_busy", {31'd0, busy}, 32'd1);
            chk("settle_noval", {31'd0, out_valid}, 32'd0);
        end
        tick();
        chk("cap_valid", {31'd0, out_valid}, 32'd1);
        chk("cap_busy", {31'd0, busy}, 32'd0);
        chk("cap_letter", {6'd0, out_letter}, {6'd0, exp_letter});
        tick();
        chk("post_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #2;
        chk_pos("rst", 5'd0, 5'd0, 5'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_letter", {6'd0, out_letter}, 32'd0);
        #10 reset = 1'b1;
        tick();

        // basic keystroke
        enc_in = 26'h4;
        key(26'h1);
        chk_pos("key1", 5'd0, 5'd0, 5'd1);
        chk("key1_busy", {31'd0, busy}, 32'd1);
        chk("key1_err", {31'd0, err}, 32'd0);
        finish_settle(26'h4);

        // middle step then double step
        do_load(5'd0, 5'd3, 5'd16);
        chk_pos("ld", 5'd0, 5'd3, 5'd16);
        chk("ld_err", {31'd0, err}, 32'd0);
        key(26'h2);
        chk_pos("mstep", 5'd0, 5'd4, 5'd17);
        finish_settle(26'h4);
        enc_in = 26'h100;
        key(26'h4);
        chk_pos("dstep", 5'd1, 5'd5, 5'd18);
        key(26'h8);
        chk("busy_rej_err", {31'd0, err}, 32'd1);
        chk_pos("busy_rej", 5'd1, 5'd5, 5'd18);
        tick();
        chk("busy_rej_err_off", {31'd0, err}, 32'd0);
        tick();
        chk("busy_rej_noval", {31'd0, out_valid}, 32'd0);
        tick();
        chk("dstep_valid", {31'd0, out_valid}, 32'd1);
        chk("dstep_letter", {6'd0, out_letter}, 32'h100);
        tick();
        chk("dstep_once", {31'd0, out_valid}, 32'd0);
        chk("dstep_held", {6'd0, out_letter}, 32'h100);

        // wrap on key stepping and on manual buttons
        do_load(5'd25, 5'd25, 5'd25);
        key(26'h10);
        chk_pos("wrap_key", 5'd25, 5'd25, 5'd0);
        finish_settle(26'h100);
        rot_btn = 3'b111;
        tick();
        rot_btn = 3'b000;
        chk_pos("wrap_btn", 5'd0, 5'd0, 5'd1);
        chk("btn_busy", {31'd0, busy}, 32'd0);
        rot_btn = 3'b010;
        tick();
        rot_btn = 3'b000;
        chk_pos("btn_mid", 5'd0, 5'd1, 5'd1);

        // invalid keys in IDLE
        key(26'h3);
        chk("bad2_err", {31'd0, err}, 32'd1);
        chk_pos("bad2", 5'd0, 5'd1, 5'd1);
        chk("bad2_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("bad2_err_off", {31'd0, err}, 32'd0);
        key(26'h0);
        chk("bad0_err", {31'd0, err}, 32'd1);
        chk_pos("bad0", 5'd0, 5'd1, 5'd1);

        // priority: key wins over load and rot_btn
        load = 1'b1; load_pos1 = 5'd5; load_pos2 = 5'd5; load_pos3 = 5'd5; rot_btn = 3'b111;
        key(26'h8);
        load = 1'b0; rot_btn = 3'b000;
        chk_pos("prio", 5'd0, 5'd1, 5'd2);
        chk("prio_busy", {31'd0, busy}, 32'd1);
        finish_settle(26'h100);

        // out-of-range load
        do_load(5'd9, 5'd30, 5'd7);
        chk_pos("ld30", 5'd9, 5'd0, 5'd7);
        chk("ld30_err", {31'd0, err}, 32'd1);
        tick();
        chk("ld30_err_off", {31'd0, err}, 32'd0);

        // asynchronous reset in the middle of SETTLE
        enc_in = 26'h2000000;
        key(26'h1);
        chk_pos("pre_rst", 5'd9, 5'd0, 5'd8);
        tick();
        #2 reset = 1'b0;
        #1;
        chk_pos("mid_rst", 5'd0, 5'd0, 5'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_letter", {6'd0, out_letter}, 32'd0);
        #2 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_noval", {31'd0, out_valid}, 32'd0);
            chk("rst_nobusy", {31'd0, busy}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
